// File: rtl/gpr_wb_pkg.sv
// gpr_wb_pkg: shared widths and types for the GPR writeback arbiter and its scoreboard.
package gpr_wb_pkg;
    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef logic [NREG-1:0] pend_vec_t;
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: pending-write vector; issue sets a bit, the write-port cycle clears it, set wins on collision.
module gpr_scoreboard
    import gpr_wb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] q_rs1,
    input  logic [AW-1:0] q_rs2,
    output logic          busy1,
    output logic          busy2
);
    pend_vec_t pending, set_mask, clr_mask;

    // A register whose write is on the port this cycle is free to be reissued.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
        issue_ready = issue_rd == '0 || !pending[issue_rd] || clr_mask[issue_rd];
        if (issue_valid && issue_ready && issue_rd != '0) set_mask[issue_rd] = 1'b1;
        busy1 = q_rs1 != '0 && pending[q_rs1];
        busy2 = q_rs2 != '0 && pending[q_rs2];
    end

    // Clear first, then set, so a same-edge reissue keeps the bit.
    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else pending <= (pending & ~clr_mask) | set_mask;
    end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: EX/LS writeback arbitration with starvation guard, registered RF write port, RAW scoreboard.
// Build option GPR_WB_BYPASS_EN adds forwarding of the in-flight write to the query ports.
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ls_valid,
    output logic            ls_ready,
    input  logic [AW-1:0]   ls_rd,
    input  logic [XLEN-1:0] ls_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic [AW-1:0]   q_rs1,
    input  logic [AW-1:0]   q_rs2,
    output logic            q_busy1,
    output logic            q_busy2,
`ifdef GPR_WB_BYPASS_EN
    output logic            q_fwd1,
    output logic            q_fwd2,
    output logic [XLEN-1:0] q_fwd_data,
`endif
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_wr_n
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] starve;
    logic       ex_win, grant, busy1, busy2;
    wb_req_t    req;

    // LS wins unless EX has lost STARVE_MAX times in a row.
    always_comb begin
        ex_win   = ex_valid && (!ls_valid || starve == SMAX);
        ex_ready = !reset && ex_win;
        ls_ready = !reset && ls_valid && !ex_win;
        grant    = ex_ready || ls_ready;
        req.rd   = ex_win ? ex_rd : ls_rd;
        req.data = ex_win ? ex_data : ls_data;
    end

    // Count consecutive EX losses, saturating; any EX grant or idle EX clears.
    always_ff @(posedge clk) begin
        if (reset || !ex_valid || ex_ready) starve <= '0;
        else if (ls_valid && starve != SMAX) starve <= starve + 4'd1;
    end

    // Registered write port: one-cycle active-low strobe per granted non-x0 write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr_n  <= 1'b1;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant) begin
            rf_wr_n  <= req.rd == '0;
            rf_waddr <= req.rd;
            rf_wdata <= req.data;
        end else begin
            rf_wr_n  <= 1'b1;
        end
    end

    gpr_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .clr_en     (!rf_wr_n),
        .clr_rd     (rf_waddr),
        .q_rs1      (q_rs1),
        .q_rs2      (q_rs2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

`ifdef GPR_WB_BYPASS_EN
    assign q_fwd1     = !rf_wr_n && rf_waddr == q_rs1 && q_rs1 != '0;
    assign q_fwd2     = !rf_wr_n && rf_waddr == q_rs2 && q_rs2 != '0;
    assign q_fwd_data = rf_wdata;
    assign q_busy1    = busy1 && !q_fwd1;
    assign q_busy2    = busy2 && !q_fwd2;
`else
    assign q_busy1    = busy1;
    assign q_busy2    = busy2;
`endif
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed scoreboard bench for gpr_wb_arbiter (also covers GPR_WB_BYPASS_EN builds).
module tb_gpr_wb_arbiter;
    import gpr_wb_pkg::*;

    localparam int SM = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid, ex_ready, ls_valid, ls_ready;
    logic [AW-1:0]   ex_rd, ls_rd, issue_rd, q_rs1, q_rs2, rf_waddr;
    logic [XLEN-1:0] ex_data, ls_data, rf_wdata;
    logic            issue_valid, issue_ready, q_busy1, q_busy2, rf_wr_n;
`ifdef GPR_WB_BYPASS_EN
    logic            q_fwd1, q_fwd2;
    logic [XLEN-1:0] q_fwd_data;
`endif

    gpr_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_rd(ls_rd), .ls_data(ls_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
`ifdef GPR_WB_BYPASS_EN
        .q_fwd1(q_fwd1), .q_fwd2(q_fwd2), .q_fwd_data(q_fwd_data),
`endif
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wr_n(rf_wr_n)
    );

    always #5 clk = ~clk;

    int      tests = 0;
    int      fails = 0;
    int      mcnt  = 0;
    wb_req_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge: check write port against queue, check grants against the model.
    task automatic tick();
        wb_req_t e;
        logic    eg, lg;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_n_active", rf_wr_n, 1'b0);
            chk("waddr", rf_waddr, e.rd);
            chk("wdata", rf_wdata, e.data);
        end else chk("wr_n_idle", rf_wr_n, 1'b1);
        eg = !reset && ex_valid && (!ls_valid || mcnt == SM);
        lg = !reset && ls_valid && !eg;
        chk("ex_ready", ex_ready, eg);
        chk("ls_ready", ls_ready, lg);
        if (eg && ex_rd != 0) exp_q.push_back('{rd: ex_rd, data: ex_data});
        if (lg && ls_rd != 0) exp_q.push_back('{rd: ls_rd, data: ls_data});
        if (reset || !ex_valid || eg) mcnt = 0;
        else if (ls_valid && mcnt < SM) mcnt++;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ex_valid = 0; ls_valid = 0; issue_valid = 0;
        ex_rd = 0; ls_rd = 0; issue_rd = 0; q_rs1 = 0; q_rs2 = 0;
        ex_data = 0; ls_data = 0;
        tick();
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        nxt();
        reset = 1'b0;

        // single EX write
        ex_valid = 1; ex_rd = 5; ex_data = 64'hA5;
        tick(); nxt();
        ex_valid = 0;
        tick(); nxt();

        // starvation guard: LS x4, EX once, LS again
        ex_valid = 1; ex_rd = 3; ex_data = 64'h33; ls_valid = 1;
        for (int i = 0; i < 6; i++) begin
            ls_rd = 4; ls_data = 64'h100 + 64'(i);
            tick();
            chk("starve_ex", ex_ready, i == 4);
            chk("starve_ls", ls_ready, i != 4);
            nxt();
        end
        ex_valid = 0; ls_valid = 0;
        tick(); nxt();

        // scoreboard RAW on rd=7
        issue_valid = 1; issue_rd = 7; q_rs1 = 7;
        tick();
        chk("iss7_ready", issue_ready, 1'b1);
        chk("busy7_pre", q_busy1, 1'b0);
        nxt();
        tick();
        chk("iss7_again", issue_ready, 1'b0);
        chk("busy7_set", q_busy1, 1'b1);
        nxt();
        issue_valid = 0; ls_valid = 1; ls_rd = 7; ls_data = 64'h77;
        tick();
        chk("busy7_grant", q_busy1, 1'b1);
        nxt();
        ls_valid = 0;
        tick();
`ifdef GPR_WB_BYPASS_EN
        chk("busy7_fwd", q_busy1, 1'b0);
        chk("fwd1", q_fwd1, 1'b1);
        chk("fwd2", q_fwd2, 1'b0);
        chk("fwd_data", q_fwd_data, 64'h77);
`else
        chk("busy7_wr", q_busy1, 1'b1);
`endif
        nxt();
        tick();
        chk("busy7_clr", q_busy1, 1'b0);
        nxt();

        // x0 write and issue
        ex_valid = 1; ex_rd = 0; ex_data = 64'hFF; issue_valid = 1; issue_rd = 0; q_rs1 = 0;
        tick();
        chk("x0_issue_ready", issue_ready, 1'b1);
        nxt();
        ex_valid = 0; issue_valid = 0;
        tick();
        chk("x0_busy", q_busy1, 1'b0);
        nxt();

        // same-edge clear and reissue of rd=9
        issue_valid = 1; issue_rd = 9; q_rs2 = 9;
        tick(); nxt();
        issue_valid = 0; ls_valid = 1; ls_rd = 9; ls_data = 64'h99;
        tick();
        chk("r9_blocked", issue_ready, 1'b0);
        nxt();
        ls_valid = 0; issue_valid = 1;
        tick();
        chk("r9_reissue_ready", issue_ready, 1'b1);
        nxt();
        issue_valid = 0; ls_valid = 1; ls_data = 64'h999;
        tick();
        chk("r9_still_busy", q_busy2, 1'b1);
        nxt();
        ls_valid = 0;
        tick(); nxt();
        tick();
        chk("r9_cleared", q_busy2, 1'b0);
        nxt();

        // reset in the cycle after a grant
        issue_valid = 1; issue_rd = 13; q_rs2 = 13;
        tick(); nxt();
        issue_valid = 0; ex_valid = 1; ex_rd = 12; ex_data = 64'hC0FFEE;
        tick();
        chk("r13_busy", q_busy2, 1'b1);
        nxt();
        ex_valid = 0; reset = 1;
        tick(); nxt();
        tick();
        chk("rst_pending", q_busy2, 1'b0);
        nxt();
        reset = 0;
        tick();
        chk("post_rst_busy", q_busy2, 1'b0);
        chk("q_empty", exp_q.size(), 0);
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
